mips_multicycle_ctrl: RTL and testbench

//  Moore-style main control FSM for the multi-cycle MIPS-subset datapath.

---
 rtl/mips_multicycle_ctrl_pkg.sv | 50 +++++
 rtl/mips_multicycle_ctrl_if.sv | 10 +
 rtl/mips_multicycle_ctrl_alu_decoder.sv | 27 ++
 rtl/mips_multicycle_ctrl.sv | 179 +++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset control path:
// opcodes, functs, ALU operations, mux select codes and FSM states.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_B       = 2'd0;
  localparam logic [1:0] SRCB_FOUR    = 2'd1;
  localparam logic [1:0] SRCB_IMM     = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_I_EXEC   = 4'd8,
    S_I_WB     = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Shared instruction/data memory handshake between the controller and memory.
interface mips_multicycle_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic iord;
  logic mem_ack;

  modport master (output mem_req, output mem_we, output iord, input mem_ack);
  modport slave  (input mem_req, input mem_we, input iord, output mem_ack);
endinterface

// File: rtl/mips_multicycle_ctrl_alu_decoder.sv
// R-type funct field to ALU operation; flags functs outside the subset.
module alu_decoder
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned OPW  = 6,
  parameter int unsigned ALUW = 3
) (
  input  logic [OPW-1:0]  funct,
  output logic [ALUW-1:0] alu_op,
  output logic            funct_illegal
);

  // Pure table lookup; unknown functs report AND and raise the flag.
  always_comb begin
    alu_op        = ALU_AND;
    funct_illegal = 1'b0;
    case (funct)
      FN_ADD:  alu_op = ALU_ADD;
      FN_SUB:  alu_op = ALU_SUB;
      FN_AND:  alu_op = ALU_AND;
      FN_OR:   alu_op = ALU_OR;
      FN_SLT:  alu_op = ALU_SLT;
      default: funct_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multi-cycle MIPS-subset datapath. Moore outputs
// per state, except the memory-completion strobes that follow mem_ack.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned OPW  = 6,
  parameter int unsigned ALUW = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [OPW-1:0]        opcode,
  input  logic [OPW-1:0]        funct,
  input  logic                  zero,
  mips_multicycle_ctrl_if.master mem,
  output logic                  ir_write,
  output logic                  pc_write,
  output logic [1:0]            pc_src,
  output logic                  reg_write,
  output logic                  reg_dst,
  output logic                  mem_to_reg,
  output logic                  alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [ALUW-1:0]       alu_op,
  output logic                  ext_sel,
  output logic                  illegal_op,
  output logic                  retire
);

  state_t          state, next_state;
  logic [ALUW-1:0] r_alu_op;
  logic            funct_illegal;

  alu_decoder #(.OPW(OPW), .ALUW(ALUW)) u_alu_decoder (
    .funct         (funct),
    .alu_op        (r_alu_op),
    .funct_illegal (funct_illegal)
  );

  // State register; reset returns to FETCH.
  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= next_state;
  end

  // Next-state and output decode.
  always_comb begin
    next_state  = state;
    mem.mem_req = 1'b0;
    mem.mem_we  = 1'b0;
    mem.iord    = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = PCSRC_ALU;
    reg_write   = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = SRCB_B;
    alu_op      = ALU_AND;
    ext_sel     = 1'b0;
    illegal_op  = 1'b0;
    retire      = 1'b0;
    case (state)
      S_FETCH: begin
        mem.mem_req = 1'b1;
        alu_src_b   = SRCB_FOUR;
        alu_op      = ALU_ADD;
        ext_sel     = 1'b1;
        if (mem.mem_ack) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          next_state = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH2;
        ext_sel   = 1'b1;
        alu_op    = ALU_ADD;
        case (opcode)
          OP_RTYPE:               next_state = S_R_EXEC;
          OP_LW, OP_SW:           next_state = S_MEM_ADDR;
          OP_ADDI, OP_ANDI, OP_ORI: next_state = S_I_EXEC;
          OP_BEQ:                 next_state = S_BRANCH;
          OP_J:                   next_state = S_JUMP;
          default: begin
            illegal_op = 1'b1;
            next_state = S_FETCH;
          end
        endcase
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = r_alu_op;
        if (funct_illegal) begin
          illegal_op = 1'b1;
          next_state = S_FETCH;
        end else begin
          next_state = S_R_WB;
        end
      end
      S_R_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        retire     = 1'b1;
        next_state = S_FETCH;
      end
      S_I_EXEC: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        next_state = S_I_WB;
        case (opcode)
          OP_ANDI: alu_op = ALU_AND;
          OP_ORI:  alu_op = ALU_OR;
          default: begin
            alu_op  = ALU_ADD;
            ext_sel = 1'b1;
          end
        endcase
      end
      S_I_WB: begin
        reg_write  = 1'b1;
        retire     = 1'b1;
        next_state = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        ext_sel    = 1'b1;
        alu_op     = ALU_ADD;
        next_state = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem.mem_req = 1'b1;
        mem.iord    = 1'b1;
        if (mem.mem_ack) next_state = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        next_state = S_FETCH;
      end
      S_MEM_WR: begin
        mem.mem_req = 1'b1;
        mem.mem_we  = 1'b1;
        mem.iord    = 1'b1;
        if (mem.mem_ack) begin
          retire     = 1'b1;
          next_state = S_FETCH;
        end
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = ALU_SUB;
        pc_src     = PCSRC_ALUOUT;
        pc_write   = zero;
        retire     = 1'b1;
        next_state = S_FETCH;
      end
      S_JUMP: begin
        pc_src     = PCSRC_JUMP;
        pc_write   = 1'b1;
        retire     = 1'b1;
        next_state = S_FETCH;
      end
      default: next_state = S_FETCH;
    endcase
    // Reset wins even in the cycle it is asserted: no architectural writes
    // or event pulses escape while the state register is being cleared.
    if (reset) begin
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      reg_write  = 1'b0;
      illegal_op = 1'b0;
      retire     = 1'b0;
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench: directed instruction sequences with literal
// expectations, then randomized instruction/ack/reset traffic compared
// every cycle against a per-instruction step model.
module tb_mips_multicycle_ctrl;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       ext_sel;
    logic       illegal_op;
    logic       retire;
  } outs_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode, funct;
  logic       zero;
  logic       ir_write, pc_write, reg_write, reg_dst, mem_to_reg, alu_src_a;
  logic       ext_sel, illegal_op, retire;
  logic [1:0] pc_src, alu_src_b;
  logic [2:0] alu_op;

  mips_multicycle_ctrl_if mem_if ();

  mips_multicycle_ctrl #(.OPW(6), .ALUW(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .mem        (mem_if),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .ext_sel    (ext_sel),
    .illegal_op (illegal_op),
    .retire     (retire)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  bit          compare_en = 1'b0;
  int          step = 0;  // cycles into the current instruction, 0 = fetch

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  function automatic bit is_legal_op(input logic [5:0] op);
    return op inside {6'b000000, 6'b100011, 6'b101011, 6'b001000,
                      6'b001100, 6'b001101, 6'b000100, 6'b000010};
  endfunction

  function automatic bit is_legal_fn(input logic [5:0] fn);
    return fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  endfunction

  function automatic logic [2:0] r_alu(input logic [5:0] fn);
    case (fn)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b000;
    endcase
  endfunction

  function automatic bit is_i(input logic [5:0] op);
    return op inside {6'b001000, 6'b001100, 6'b001101};
  endfunction

  function automatic outs_t model_outs(input int s, input logic [5:0] op, input logic [5:0] fn,
                                       input logic ack, input logic z, input logic rst);
    outs_t o;
    o = '0;
    case (s)
      0: begin
        o.mem_req = 1; o.alu_src_b = 2'd1; o.alu_op = 3'b010; o.ext_sel = 1;
        o.ir_write = ack; o.pc_write = ack;
      end
      1: begin
        o.alu_src_b = 2'd3; o.ext_sel = 1; o.alu_op = 3'b010;
        o.illegal_op = !is_legal_op(op);
      end
      2: begin
        if (op == 6'b000000) begin
          o.alu_src_a = 1; o.alu_op = r_alu(fn); o.illegal_op = !is_legal_fn(fn);
        end else if (is_i(op)) begin
          o.alu_src_a = 1; o.alu_src_b = 2'd2;
          o.alu_op  = (op == 6'b001100) ? 3'b000 : (op == 6'b001101) ? 3'b001 : 3'b010;
          o.ext_sel = (op == 6'b001000);
        end else if (op == 6'b100011 || op == 6'b101011) begin
          o.alu_src_a = 1; o.alu_src_b = 2'd2; o.ext_sel = 1; o.alu_op = 3'b010;
        end else if (op == 6'b000100) begin
          o.alu_src_a = 1; o.alu_op = 3'b110; o.pc_src = 2'd1; o.pc_write = z; o.retire = 1;
        end else begin
          o.pc_src = 2'd2; o.pc_write = 1; o.retire = 1;
        end
      end
      3: begin
        if (op == 6'b000000) begin
          o.reg_write = 1; o.reg_dst = 1; o.retire = 1;
        end else if (is_i(op)) begin
          o.reg_write = 1; o.retire = 1;
        end else if (op == 6'b100011) begin
          o.mem_req = 1; o.iord = 1;
        end else begin
          o.mem_req = 1; o.mem_we = 1; o.iord = 1; o.retire = ack;
        end
      end
      default: begin
        o.reg_write = 1; o.mem_to_reg = 1; o.retire = 1;
      end
    endcase
    if (rst) begin
      o.ir_write = 0; o.pc_write = 0; o.reg_write = 0; o.illegal_op = 0; o.retire = 0;
    end
    return o;
  endfunction

  function automatic int model_next(input int s, input logic [5:0] op, input logic [5:0] fn,
                                    input logic ack);
    case (s)
      0: return ack ? 1 : 0;
      1: return is_legal_op(op) ? 2 : 0;
      2: begin
        if (op == 6'b000000) return is_legal_fn(fn) ? 3 : 0;
        if (op == 6'b000100 || op == 6'b000010) return 0;
        return 3;
      end
      3: begin
        if (op == 6'b100011) return ack ? 4 : 3;
        if (op == 6'b101011) return ack ? 0 : 3;
        return 0;
      end
      default: return 0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (reset) step = 0;
    else       step = model_next(step, opcode, funct, mem_if.mem_ack);
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    outs_t act, exp;
    if (compare_en) begin
      act = {mem_if.mem_req, mem_if.mem_we, mem_if.iord, ir_write, pc_write, pc_src,
             reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
             ext_sel, illegal_op, retire};
      exp = model_outs(step, opcode, funct, mem_if.mem_ack, zero, reset);
      check($sformatf("model_step%0d_op%0h", step, opcode), 32'(act), 32'(exp));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Fetch with `waits` unacknowledged cycles; leaves the DUT in DECODE.
  task automatic do_fetch(input logic [5:0] op, input logic [5:0] fn, input int waits);
    opcode = op;
    funct  = fn;
    mem_if.mem_ack = 1'b0;
    repeat (waits) tick();
    mem_if.mem_ack = 1'b1;
    #1 check("fetch_ir_pc_write", {ir_write, pc_write}, 2'b11);
    tick();
    mem_if.mem_ack = 1'b0;
  endtask

  logic [5:0] op_tab [10] = '{6'b000000, 6'b000000, 6'b100011, 6'b101011, 6'b001000,
                              6'b001100, 6'b001101, 6'b000100, 6'b000010, 6'b111111};
  logic [5:0] fn_tab [6]  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000111};

  initial begin
    reset = 1'b1; opcode = '0; funct = '0; zero = 1'b0; mem_if.mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_req", mem_if.mem_req, 1);
    check("rst_fetch_drive", {alu_src_b, alu_op, ext_sel}, {2'd1, 3'b010, 1'b1});
    check("rst_write_en", {ir_write, pc_write, reg_write, mem_if.mem_we}, 4'b0000);
    #1 reset = 1'b0;
    compare_en = 1'b1;

    // addi with two fetch wait cycles
    do_fetch(6'b001000, 6'h00, 2);
    #1 check("dec_src_b", alu_src_b, 2'd3);
    tick(); #1 check("addi_exec", {ext_sel, alu_op}, {1'b1, 3'b010});
    tick(); #1 check("addi_wb", {reg_write, reg_dst, retire}, 3'b101);
    tick(); #1 check("addi_done", {retire, mem_if.mem_req}, 2'b01);

    // ori / andi zero-extend
    do_fetch(6'b001101, 6'h00, 0);
    tick(); #1 check("ori_exec", {ext_sel, alu_op}, {1'b0, 3'b001});
    tick(); tick();
    do_fetch(6'b001100, 6'h00, 0);
    tick(); #1 check("andi_exec", {ext_sel, alu_op}, {1'b0, 3'b000});
    tick(); tick();

    // lw with 3-cycle memory latency
    do_fetch(6'b100011, 6'h00, 0);
    tick(); tick();
    repeat (3) begin
      #1 check("lw_wait", {mem_if.mem_req, mem_if.iord, mem_if.mem_we}, 3'b110);
      tick();
    end
    mem_if.mem_ack = 1'b1; tick(); mem_if.mem_ack = 1'b0;
    #1 check("lw_wb", {reg_write, mem_to_reg, reg_dst, retire}, 4'b1101);
    tick();

    // sw with 3-cycle memory latency
    do_fetch(6'b101011, 6'h00, 0);
    tick(); tick();
    repeat (3) begin
      #1 check("sw_wait", {mem_if.mem_req, mem_if.mem_we, mem_if.iord, reg_write, retire}, 5'b11100);
      tick();
    end
    mem_if.mem_ack = 1'b1;
    #1 check("sw_ack", {retire, reg_write}, 2'b10);
    tick(); mem_if.mem_ack = 1'b0;

    // beq taken / not taken, jump
    do_fetch(6'b000100, 6'h00, 0); zero = 1'b1;
    tick(); #1 check("beq_taken", {pc_write, pc_src, alu_op}, {1'b1, 2'd1, 3'b110});
    tick();
    do_fetch(6'b000100, 6'h00, 0); zero = 1'b0;
    tick(); #1 check("beq_not_taken", {pc_write, pc_src}, {1'b0, 2'd1});
    tick();
    do_fetch(6'b000010, 6'h00, 0);
    tick(); #1 check("jump", {pc_write, pc_src, retire}, {1'b1, 2'd2, 1'b1});
    tick();

    // illegal opcode and funct
    do_fetch(6'b111111, 6'h00, 0);
    #1 check("illegal_op_pulse", illegal_op, 1);
    tick(); #1 check("illegal_op_back", {illegal_op, mem_if.mem_req, mem_if.iord}, 3'b010);
    do_fetch(6'b000000, 6'b000111, 0);
    tick(); #1 check("illegal_fn_pulse", {illegal_op, reg_write}, 2'b10);
    tick(); #1 check("illegal_fn_back", {illegal_op, reg_write, mem_if.mem_req}, 3'b001);

    // reset in MEM_RD
    do_fetch(6'b100011, 6'h00, 0);
    tick(); tick();
    reset = 1'b1;
    #1 check("rst_memrd_no_write", reg_write, 0);
    tick(); reset = 1'b0;
    #1 check("rst_memrd_refetch", {mem_if.iord, reg_write, mem_if.mem_req}, 3'b001);

    // randomized traffic
    repeat (3000) begin
      if (step == 0) begin
        opcode = op_tab[$urandom_range(0, 9)];
        funct  = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fn_tab[$urandom_range(0, 5)];
        if ($urandom_range(0, 15) == 0) opcode = 6'($urandom);
      end
      zero           = 1'($urandom);
      mem_if.mem_ack = ($urandom_range(0, 2) == 0);
      reset          = ($urandom_range(0, 63) == 0);
      tick();
    end
    reset = 1'b0;
    tick();
    compare_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
